// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: controller states, register-index width,
// default drain length and the canned control-signal bundles for each pipeline mode.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W         = 5;
    localparam int DRAIN_CYC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_HOLD   = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_DRAIN  = '{pc_write: 1'b0, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID/EX load and the IF/ID consumer.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    output logic             hazard_o
);

    logic rs_match;
    logic rt_match;

    // r0 is hard-wired zero, so a load into it can never create a dependency.
    assign rs_match = (idex_rt_i == ifid_rs_i);
    assign rt_match = ifid_uses_rt_i && (idex_rt_i == ifid_rt_i);
    assign hazard_o = idex_memread_i && (idex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: IDLE/RUN/DRAIN run-control FSM, stall/flush steering
// and saturating performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_bubble_o,
    output logic             ifid_flush_o,
    output logic             run_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    pipe_ctrl_t       ctrl;
    logic             hazard;
    logic             in_run;

    load_use_detect u_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .hazard_o       (hazard)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        ctrl    = CTRL_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                // A stalled branch is re-presented next cycle, so the stall wins over the flush.
                if (hazard)                        ctrl = CTRL_HOLD;
                else if (branch_taken_i || jump_i) ctrl = CTRL_FLUSH;
                else                               ctrl = CTRL_NORMAL;
                if (!start_i) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                ctrl = CTRL_DRAIN;
                if (start_i) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_run = (state_q == ST_RUN);
    assign run_o  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        cycle_d = cycle_q;
        if (in_run && hazard && (stall_q != '1))          stall_d = stall_q + CNT_W'(1);
        if (in_run && ctrl.ifid_flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
        if (run_o && (cycle_q != '1))                     cycle_d = cycle_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            cycle_q <= cycle_d;
        end
    end

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_write_o  = ctrl.ifid_write;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign stall_cnt_o   = stall_q;
    assign flush_cnt_o   = flush_q;
    assign cycle_cnt_o   = cycle_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of each performance counter.
REQ-002 The block SHALL have parameter DRAIN_CYC, default 4, giving the number of cycles to retire in-flight instructions after stop.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 start_i  input  1  level; 1 = CPU runs, 0 = request stop.
REQ-006 idex_memread_i  input  1  instruction in ID/EX is a load.
REQ-007 idex_rt_i  input  5  destination register of the ID/EX load.
REQ-008 ifid_rs_i, ifid_rt_i  input  5 each  source registers of the IF/ID instruction.
REQ-009 ifid_uses_rt_i  input  1  IF/ID instruction reads rt as an operand.
REQ-010 branch_taken_i  input  1  branch resolved taken in ID this cycle.
REQ-011 jump_i  input  1  jump decoded in ID this cycle.
REQ-012 pc_write_o  output  1  enable for the PC register.
REQ-013 ifid_write_o  output  1  enable for the IF/ID register.
REQ-014 idex_bubble_o  output  1  forces ID/EX control fields to zero.
REQ-015 ifid_flush_o  output  1  clears IF/ID to a nop.
REQ-016 run_o  output  1  1 while in RUN or DRAIN.
REQ-017 stall_cnt_o, flush_cnt_o, cycle_cnt_o  output  CNT_W each  performance counters.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN; reset state IDLE.
REQ-019 IDLE->RUN when start_i=1; RUN->DRAIN when start_i=0; DRAIN->IDLE when the drain counter reaches DRAIN_CYC-1; DRAIN->RUN if start_i=1 (drain counter cleared).
REQ-020 Hazard detection SHALL be combinational: hazard = idex_memread_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
REQ-021 In RUN with hazard=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
REQ-022 In RUN with hazard=0 and (branch_taken_i|jump_i)=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0.
REQ-023 Hazard SHALL take priority over branch/jump in the same cycle; the flush is suppressed and the branch re-resolves the next cycle.
REQ-024 In RUN with no hazard and no branch/jump: pc_write_o=1, ifid_write_o=1, others 0.
REQ-025 In IDLE: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
REQ-026 In DRAIN: pc_write_o=0, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0, so nops enter behind retiring instructions; hazard and branch inputs are ignored.
REQ-027 cycle_cnt_o SHALL increment every cycle run_o=1.
REQ-028 stall_cnt_o SHALL increment on each RUN cycle with hazard=1 (branch/jump cycles not counted).
REQ-029 flush_cnt_o SHALL increment on each RUN cycle with ifid_flush_o=1.
REQ-030 Counters SHALL saturate at all-ones, hold in IDLE, and clear only on reset.
REQ-031 All counter and state updates SHALL be visible one cycle after the qualifying cycle.

Reset
REQ-032 On rst_i=0, asynchronously: state=IDLE, drain counter=0, all counters=0, run_o=0; outputs take IDLE values per REQ-025.
REQ-033 Reset asserted mid-RUN or mid-DRAIN SHALL abort immediately, with no drain.

Structure
REQ-034 State encodings (IDLE=0, RUN=1, DRAIN=2) and the DRAIN_CYC default SHALL be defined in the shared CPU package.
REQ-035 Hazard compare logic SHALL be a sub-module, load_use_detect; the FSM and counters reside in pipe_hazard_ctrl.

Verification
REQ-036 Reset, start_i=1 at cycle 0 -> run_o=1 at cycle 1, pc_write_o=1, all counters 0.
REQ-037 RUN, idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for 1 cycle -> pc_write_o=0, idex_bubble_o=1 that cycle; stall_cnt_o=1 next cycle.
REQ-038 Same load hazard plus branch_taken_i=1 in one cycle -> ifid_flush_o=0, stall_cnt_o +1, flush_cnt_o unchanged.
REQ-039 idex_rt_i=0 with a matching rs, or ifid_uses_rt_i=0 with a matching rt only -> no stall.
REQ-040 jump_i=1 for 3 cycles -> flush_cnt_o=3; then start_i=0 -> DRAIN for 4 cycles, then IDLE, and cycle_cnt_o frozen.
REQ-041 Counters preset near all-ones with stall every cycle -> stall_cnt_o holds all-ones; rst_i=0 mid-DRAIN -> IDLE and all counters 0 immediately.
